ps2_key_event_sequencer: RTL and testbench

Turns the raw PS/2 byte stream (scan-code bytes with a one-cycle strobe) into one clean keystroke event per press/release. Each event is buffered in a small FIFO and handed to the encryption datapath over a valid/ready handshake. A one-cycle `advance` pulse is raised per accepted keystroke to step the rotors. It supersedes the fixed IDLE/MAKE/BREAK/WAIT keystroke machine in the top level, and adds:
- E0 extended-code handling
- typematic-repeat suppression
- a parametrised hold-off
- event buffering with overflow reporting

---
 rtl/ps2_key_event_sequencer_if.sv | 27 ++
 rtl/ps2_key_event_sequencer.sv | 165 ++++++++++++++++
 tb/tb_ps2_key_event_sequencer.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ps2_key_event_sequencer_if.sv
// Byte-in / event-out bundle for the PS/2 keystroke sequencer.
// The sequencer side uses the master modport and the consumer side uses the slave modport.
interface ps2_key_event_sequencer_if #(
  parameter int FIFO_DEPTH = 4
);
  logic [7:0]                  rx_data;
  logic                        rx_en;
  logic                        evt_ready;
  logic                        evt_valid;
  logic [7:0]                  evt_code;
  logic                        evt_ext;
  logic                        advance;
  logic                        busy;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;
  logic                        overflow;
  logic [7:0]                  last_code;

  modport master (
    input  rx_data, rx_en, evt_ready,
    output evt_valid, evt_code, evt_ext, advance, busy, fifo_count, overflow, last_code
  );

  modport slave (
    output rx_data, rx_en, evt_ready,
    input  evt_valid, evt_code, evt_ext, advance, busy, fifo_count, overflow, last_code
  );
endinterface

// File: rtl/ps2_key_event_sequencer.sv
// Turns the PS/2 scan-code byte stream into one buffered event per keystroke.
// It also emits a rotor-advance pulse for each event that is accepted into the FIFO.
module ps2_key_event_sequencer #(
  parameter int FIFO_DEPTH     = 4,
  parameter int HOLDOFF_CYCLES = 5000,
  parameter int CNT_W          = 13
) (
  input  logic CLOCK_50,
  input  logic reset,
  ps2_key_event_sequencer_if.master bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [7:0]       CODE_EXT  = 8'hE0;
  localparam logic [7:0]       CODE_BRK  = 8'hF0;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLDOFF_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_MAKE    = 3'd1,
    S_BREAK   = 3'd2,
    S_HOLDOFF = 3'd3,
    S_SKIP    = 3'd4
  } state_t;

  state_t           state, state_next;
  logic [7:0]       held, held_next;
  logic             held_ext, held_ext_next;
  logic             pend_ext, pend_ext_next;
  logic             brk_ext, brk_ext_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             commit;

  logic [8:0]       mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;
  logic             full, push, pop;
  logic             overflow_r, advance_r;
  logic [7:0]       last_code_r;

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state    <= S_IDLE;
      held     <= '0;
      held_ext <= 1'b0;
      pend_ext <= 1'b0;
      brk_ext  <= 1'b0;
      cnt      <= '0;
    end else begin
      state    <= state_next;
      held     <= held_next;
      held_ext <= held_ext_next;
      pend_ext <= pend_ext_next;
      brk_ext  <= brk_ext_next;
      cnt      <= cnt_next;
    end
  end

  always_comb begin
    state_next    = state;
    held_next     = held;
    held_ext_next = held_ext;
    pend_ext_next = pend_ext;
    brk_ext_next  = brk_ext;
    cnt_next      = cnt;
    commit        = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.rx_en) begin
          if (bus.rx_data == CODE_EXT) begin
            pend_ext_next = 1'b1;
          end else if (bus.rx_data == CODE_BRK) begin
            state_next = S_SKIP;
          end else begin
            held_next     = bus.rx_data;
            held_ext_next = pend_ext;
            pend_ext_next = 1'b0;
            state_next    = S_MAKE;
          end
        end
      end
      // Repeats of the held code are typematic; other new keys are ignored because there is no rollover support.
      S_MAKE: begin
        if (bus.rx_en && bus.rx_data != held) begin
          if (bus.rx_data == CODE_EXT) begin
            brk_ext_next = 1'b1;
          end else if (bus.rx_data == CODE_BRK) begin
            state_next = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        if (bus.rx_en && bus.rx_data != CODE_EXT) begin
          if (bus.rx_data == held && brk_ext == held_ext) begin
            commit       = 1'b1;
            brk_ext_next = 1'b0;
            cnt_next     = '0;
            state_next   = S_HOLDOFF;
          end else begin
            brk_ext_next = 1'b0;
            state_next   = S_MAKE;
          end
        end
      end
      S_HOLDOFF: begin
        if (cnt == HOLD_LAST) begin
          state_next = S_IDLE;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      S_SKIP: begin
        if (bus.rx_en && bus.rx_data != CODE_EXT) begin
          pend_ext_next = 1'b0;
          state_next    = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // A commit that meets a full FIFO still gets in when the head is popped in the same cycle.
  assign full = (count == CW'(FIFO_DEPTH));
  assign pop  = (count != '0) && bus.evt_ready;
  assign push = commit && (!full || pop);

  always_ff @(posedge CLOCK_50) begin
    if (push) begin
      mem[wr_ptr] <= {held_ext, held};
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      overflow_r  <= 1'b0;
      advance_r   <= 1'b0;
      last_code_r <= '0;
    end else begin
      if (push) begin
        wr_ptr      <= wr_ptr + AW'(1);
        last_code_r <= held;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (commit && !push) begin
        overflow_r <= 1'b1;
      end
      count     <= count + CW'(push) - CW'(pop);
      advance_r <= push;
    end
  end

  assign bus.evt_valid  = (count != '0);
  assign bus.evt_code   = bus.evt_valid ? mem[rd_ptr][7:0] : 8'h00;
  assign bus.evt_ext    = bus.evt_valid ? mem[rd_ptr][8] : 1'b0;
  assign bus.advance    = advance_r;
  assign bus.busy       = (state == S_HOLDOFF);
  assign bus.fifo_count = count;
  assign bus.overflow   = overflow_r;
  assign bus.last_code  = last_code_r;
endmodule

// File: tb/tb_ps2_key_event_sequencer.sv
// Scoreboard bench for ps2_key_event_sequencer: keystroke-level reference model, directed and random bytes.
module tb_ps2_key_event_sequencer;
  localparam int DEPTH = 4;
  localparam int HOLD  = 8;

  logic CLOCK_50 = 1'b0;
  logic reset;

  ps2_key_event_sequencer_if #(.FIFO_DEPTH(DEPTH)) bus ();

  ps2_key_event_sequencer #(
    .FIFO_DEPTH(DEPTH),
    .HOLDOFF_CYCLES(HOLD),
    .CNT_W(4)
  ) dut (
    .CLOCK_50(CLOCK_50),
    .reset(reset),
    .bus(bus)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  int checks = 0;
  int errors = 0;
  int adv_seen = 0;
  bit rand_ready = 1'b0;

  // Reference model state: FIFO contents, status flags and a keystroke-level view of the parser.
  logic [8:0] exp_q[$];
  int         m_count = 0;
  bit         m_ovf = 1'b0;
  bit         m_adv = 1'b0;
  logic [7:0] m_last = 8'h00;
  longint     now = 0;
  longint     quiet_until = -1;
  bit         key_down, releasing, rel_e0, prefix_e0, skipping, key_ext;
  logic [7:0] key;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelStep();
    bit         pop, commit;
    logic [7:0] b;
    longint     c;
    c = now;
    now++;
    m_adv = 1'b0;
    if (reset) begin
      m_count = 0; m_ovf = 1'b0; m_last = 8'h00; exp_q.delete(); quiet_until = -1;
      key_down = 0; releasing = 0; rel_e0 = 0; prefix_e0 = 0; skipping = 0; key_ext = 0; key = 8'h00;
      return;
    end
    pop    = bus.evt_ready && (m_count > 0);
    commit = 1'b0;
    if (bus.rx_en && c > quiet_until) begin
      b = bus.rx_data;
      if (skipping) begin
        if (b != 8'hE0) begin skipping = 0; prefix_e0 = 0; end
      end else if (!key_down) begin
        if (b == 8'hE0) prefix_e0 = 1;
        else if (b == 8'hF0) skipping = 1;
        else begin key_down = 1; key = b; key_ext = prefix_e0; prefix_e0 = 0; releasing = 0; rel_e0 = 0; end
      end else if (!releasing) begin
        if (b == key) ;
        else if (b == 8'hE0) rel_e0 = 1;
        else if (b == 8'hF0) releasing = 1;
      end else begin
        if (b == 8'hE0) ;
        else if (b == key && rel_e0 == key_ext) commit = 1;
        else begin releasing = 0; rel_e0 = 0; end
      end
    end
    if (commit) begin
      if (m_count < DEPTH || pop) begin
        exp_q.push_back({key_ext, key});
        m_adv = 1'b1;
        m_last = key;
        m_count++;
      end else begin
        m_ovf = 1'b1;
      end
      key_down = 0; releasing = 0; rel_e0 = 0;
      quiet_until = c + HOLD;
    end
    if (pop) m_count--;
  endtask

  initial forever begin
    @(posedge CLOCK_50);
    modelStep();
  end

  // Monitor: compares every cycle and retires the head entry when the consumer takes it.
  initial forever begin
    @(negedge CLOCK_50);
    if (bus.advance === 1'b1) adv_seen++;
    checkOutput("evt_valid", 32'(bus.evt_valid), 32'(m_count != 0));
    checkOutput("fifo_count", 32'(bus.fifo_count), 32'(m_count));
    checkOutput("advance", 32'(bus.advance), 32'(m_adv));
    checkOutput("overflow", 32'(bus.overflow), 32'(m_ovf));
    checkOutput("busy", 32'(bus.busy), 32'(now <= quiet_until));
    checkOutput("last_code", 32'(bus.last_code), 32'(m_last));
    if (m_count != 0 && exp_q.size() != 0) begin
      checkOutput("evt_code", 32'(bus.evt_code), 32'(exp_q[0][7:0]));
      checkOutput("evt_ext", 32'(bus.evt_ext), 32'(exp_q[0][8]));
      if (bus.evt_ready) void'(exp_q.pop_front());
    end
  end

  initial forever begin
    @(posedge CLOCK_50);
    #1;
    if (rand_ready) bus.evt_ready = ($urandom_range(0, 2) != 0);
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge CLOCK_50); #1; end
  endtask

  task automatic applyStimulus(input logic [7:0] b, input bit rdy_pulse = 1'b0);
    bus.rx_data = b;
    bus.rx_en   = 1'b1;
    if (rdy_pulse) bus.evt_ready = 1'b1;
    @(posedge CLOCK_50); #1;
    bus.rx_en   = 1'b0;
    bus.rx_data = 8'($urandom);
    if (rdy_pulse) bus.evt_ready = 1'b0;
  endtask

  task automatic keystroke(input logic [7:0] code, input bit ext);
    if (ext) applyStimulus(8'hE0);
    applyStimulus(code);
    if (ext) applyStimulus(8'hE0);
    applyStimulus(8'hF0);
    applyStimulus(code);
    idle(HOLD + 2);
  endtask

  task automatic pulseReset();
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_evt_valid"}, 32'(bus.evt_valid), 0);
    checkOutput({tag, "_evt_code"}, 32'(bus.evt_code), 0);
    checkOutput({tag, "_evt_ext"}, 32'(bus.evt_ext), 0);
    checkOutput({tag, "_advance"}, 32'(bus.advance), 0);
    checkOutput({tag, "_busy"}, 32'(bus.busy), 0);
    checkOutput({tag, "_fifo_count"}, 32'(bus.fifo_count), 0);
    checkOutput({tag, "_overflow"}, 32'(bus.overflow), 0);
    checkOutput({tag, "_last_code"}, 32'(bus.last_code), 0);
  endtask

  initial begin
    int         adv0;
    logic [7:0] pool [8];
    logic [7:0] ovf_keys [5];
    pool     = '{8'hE0, 8'hF0, 8'h1C, 8'h1C, 8'h75, 8'h15, 8'hF0, 8'h1C};
    ovf_keys = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C};
    reset         = 1'b1;
    bus.rx_en     = 1'b0;
    bus.rx_data   = 8'h00;
    bus.evt_ready = 1'b0;
    idle(3);
    reset = 1'b0;
    checkAllZero("reset");

    $display("[TB] plain key");
    bus.evt_ready = 1'b1;
    adv0 = adv_seen;
    keystroke(8'h1C, 1'b0);
    checkOutput("plain_advance_pulses", 32'(adv_seen - adv0), 1);
    checkOutput("plain_last_code", 32'(bus.last_code), 32'h1C);

    $display("[TB] typematic and extended");
    repeat (5) applyStimulus(8'h1C);
    applyStimulus(8'hF0);
    applyStimulus(8'h1C);
    idle(HOLD + 2);
    keystroke(8'h75, 1'b1);
    checkOutput("ext_last_code", 32'(bus.last_code), 32'h75);
    adv0 = adv_seen;
    applyStimulus(8'hE0); applyStimulus(8'h75); applyStimulus(8'hF0); applyStimulus(8'h75);
    idle(HOLD + 2);
    checkOutput("ext_mismatch_no_event", 32'(adv_seen - adv0), 0);
    applyStimulus(8'hE0); applyStimulus(8'hF0); applyStimulus(8'h75);
    idle(HOLD + 2);
    checkOutput("ext_still_in_make", 32'(adv_seen - adv0), 1);

    $display("[TB] backpressure and overflow");
    bus.evt_ready = 1'b0;
    adv0 = adv_seen;
    foreach (ovf_keys[i]) keystroke(ovf_keys[i], 1'b0);
    checkOutput("ovf_fifo_count", 32'(bus.fifo_count), 4);
    checkOutput("ovf_flag", 32'(bus.overflow), 1);
    checkOutput("ovf_advance_pulses", 32'(adv_seen - adv0), 4);
    checkOutput("ovf_head", 32'(bus.evt_code), 32'h15);
    bus.evt_ready = 1'b1;
    idle(6);
    checkOutput("ovf_drained", 32'(bus.fifo_count), 0);

    $display("[TB] full with pop");
    pulseReset();
    bus.evt_ready = 1'b0;
    for (int i = 0; i < 4; i++) keystroke(ovf_keys[i], 1'b0);
    applyStimulus(8'h2C); applyStimulus(8'hF0); applyStimulus(8'h2C, 1'b1);
    idle(2);
    checkOutput("fwp_fifo_count", 32'(bus.fifo_count), 4);
    checkOutput("fwp_overflow", 32'(bus.overflow), 0);
    checkOutput("fwp_head", 32'(bus.evt_code), 32'h1D);
    bus.evt_ready = 1'b1;
    idle(HOLD + 4);

    $display("[TB] holdoff drop and orphan break");
    adv0 = adv_seen;
    applyStimulus(8'h1C); applyStimulus(8'hF0); applyStimulus(8'h1C);
    applyStimulus(8'h1C); applyStimulus(8'hF0); applyStimulus(8'h1C);
    idle(HOLD + 2);
    applyStimulus(8'hF0); applyStimulus(8'h1C);
    idle(HOLD + 2);
    checkOutput("drop_orphan_events", 32'(adv_seen - adv0), 1);
    keystroke(8'h1C, 1'b0);
    checkOutput("after_orphan_event", 32'(adv_seen - adv0), 2);

    $display("[TB] reset mid-break");
    applyStimulus(8'h1C); applyStimulus(8'hF0);
    pulseReset();
    checkAllZero("midbreak");
    adv0 = adv_seen;
    applyStimulus(8'hF0); applyStimulus(8'h1C);
    idle(HOLD + 2);
    checkOutput("midbreak_no_event", 32'(adv_seen - adv0), 0);

    $display("[TB] random traffic");
    rand_ready = 1'b1;
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 199) == 0) pulseReset();
      applyStimulus(pool[$urandom_range(0, 7)]);
      idle($urandom_range(0, HOLD + 1));
    end
    rand_ready = 1'b0;
    bus.evt_ready = 1'b1;
    idle(HOLD + 8);
    checkOutput("final_drained", 32'(bus.fifo_count), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
